// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter
// Shares one memory command channel among num_req_p requesters. The requester
// ID of every issued command is tracked in order, so each in-order memory
// response can be steered back to the requester that issued the command.
// Build option: define BP_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority. Round-robin is used when the macro is not defined.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  localparam int lg_num_req_lp    = $clog2(num_req_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]             mem_cmd_v_i,
  output logic [num_req_p-1:0]             mem_cmd_ready_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [msg_width_p-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]             mem_resp_v_o,
  input  logic [num_req_p-1:0]             mem_resp_yumi_i,
  output logic                             error_o
);

  localparam int lg_depth_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int lg_cnt_lp    = $clog2(max_outstanding_p + 1);
  localparam int last_req_lp  = num_req_p - 1;
  localparam int last_slot_lp = max_outstanding_p - 1;

  logic [lg_num_req_lp-1:0] ptr;
  logic [lg_num_req_lp-1:0] winner;
  logic [lg_num_req_lp:0]   idx;
  logic                     found;
  logic                     can_issue;
  logic                     push;
  logic                     pop;
  logic                     non_empty;
  logic [lg_num_req_lp-1:0] head;
  logic [num_req_p-1:0]     grant;

  logic                     hold_v_q, hold_v_d;
  logic [lg_num_req_lp-1:0] hold_id_q, hold_id_d;
  logic [lg_num_req_lp-1:0] ids_q [max_outstanding_p];
  logic [lg_num_req_lp-1:0] ids_d [max_outstanding_p];
  logic [lg_depth_lp-1:0]   wptr_q, wptr_d;
  logic [lg_depth_lp-1:0]   rptr_q, rptr_d;
  logic [lg_cnt_lp-1:0]     count_q, count_d;
  logic                     error_q, error_d;

`ifdef BP_MEM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [lg_num_req_lp-1:0] ptr_q, ptr_d;

  // Round-robin pointer moves just past the winner after every accepted command
  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (winner == last_req_lp[lg_num_req_lp-1:0]) ? '0 : winner + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // Pick the winner: a stalled requester keeps its grant, otherwise search from ptr
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    if (hold_v_q && mem_cmd_v_i[hold_id_q]) begin
      found  = 1'b1;
      winner = hold_id_q;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        idx = {1'b0, ptr} + i[lg_num_req_lp:0];
        if (idx >= num_req_p[lg_num_req_lp:0]) begin
          idx = idx - num_req_p[lg_num_req_lp:0];
        end
        if (!found && mem_cmd_v_i[idx[lg_num_req_lp-1:0]]) begin
          found  = 1'b1;
          winner = idx[lg_num_req_lp-1:0];
        end
      end
    end
  end

  // Command-side outputs; the credit check uses only the registered count
  always_comb begin
    can_issue   = (count_q < max_outstanding_p[lg_cnt_lp-1:0]);
    grant       = '0;
    for (int i = 0; i < num_req_p; i++) begin
      grant[i] = found && (winner == i[lg_num_req_lp-1:0]);
    end
    mem_cmd_v_o     = found & can_issue;
    mem_cmd_ready_o = grant & {num_req_p{can_issue & mem_cmd_ready_i}};
    mem_cmd_o       = mem_cmd_i[winner*msg_width_p +: msg_width_p];
    push            = mem_cmd_v_o & mem_cmd_ready_i;
  end

  // Response steering: only the requester at the head of the ID FIFO sees valid
  always_comb begin
    non_empty       = (count_q != '0);
    head            = ids_q[rptr_q];
    mem_resp_o      = mem_resp_i;
    mem_resp_v_o    = '0;
    for (int i = 0; i < num_req_p; i++) begin
      mem_resp_v_o[i] = non_empty && mem_resp_v_i && (head == i[lg_num_req_lp-1:0]);
    end
    mem_resp_yumi_o = non_empty & mem_resp_v_i & mem_resp_yumi_i[head];
    pop             = mem_resp_yumi_o;
  end

  // Next-state for the ID FIFO, the stall hold, and the sticky stray-response flag
  always_comb begin
    ids_d     = ids_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    hold_v_d  = mem_cmd_v_o & ~mem_cmd_ready_i;
    hold_id_d = winner;
    error_d   = error_q | (mem_resp_v_i & ~non_empty);
    if (push) begin
      ids_d[wptr_q] = winner;
      wptr_d = (wptr_q == last_slot_lp[lg_depth_lp-1:0]) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == last_slot_lp[lg_depth_lp-1:0]) ? '0 : rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + lg_cnt_lp'(1);
      2'b01:   count_d = count_q - lg_cnt_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every tracked ID
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ids_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      hold_v_q  <= 1'b0;
      hold_id_q <= '0;
      error_q   <= 1'b0;
    end else begin
      ids_q     <= ids_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      hold_v_q  <= hold_v_d;
      hold_id_q <= hold_id_d;
      error_q   <= error_d;
    end
  end

  assign error_o = error_q;

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb_bp_me_mem_cmd_arbiter
// Table of hand-derived vectors, hand-written stall/stray sequences, then
// randomized traffic compared against a queue-based reference model.
module tb_bp_me_mem_cmd_arbiter;

  localparam int N = 2;
  localparam int W = 128;
  localparam int D = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N*W-1:0]   mem_cmd_i;
  logic [N-1:0]     mem_cmd_v_i;
  logic [N-1:0]     mem_cmd_ready_o;
  logic [W-1:0]     mem_cmd_o;
  logic             mem_cmd_v_o;
  logic             mem_cmd_ready_i;
  logic [W-1:0]     mem_resp_i;
  logic             mem_resp_v_i;
  logic             mem_resp_yumi_o;
  logic [W-1:0]     mem_resp_o;
  logic [N-1:0]     mem_resp_v_o;
  logic [N-1:0]     mem_resp_yumi_i;
  logic             error_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] req_data [N];

  // Reference model state: outstanding owner IDs in issue order
  int mq[$];
  int m_ptr  = 0;
  int m_hold = -1;
  bit m_err  = 1'b0;

  typedef struct {
    logic [1:0] cmd_v;
    logic       cmd_rdy;
    logic       resp_v;
    logic [1:0] yumi;
    logic       exp_cmd_v;
    logic [1:0] exp_cmd_rdy;
    int         exp_win;
    logic [1:0] exp_resp_v;
    logic       exp_yumi;
  } vec_t;

  vec_t tbl[$];

  always #5 clk_i = ~clk_i;

  bp_me_mem_cmd_arbiter #(
    .num_req_p(N), .msg_width_p(W), .max_outstanding_p(D)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
    .error_o(error_o)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic rdy, input logic rv, input logic [1:0] y);
    mem_cmd_i       = {req_data[1], req_data[0]};
    mem_cmd_v_i     = v;
    mem_cmd_ready_i = rdy;
    mem_resp_v_i    = rv;
    mem_resp_yumi_i = y;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic addRow(input logic [1:0] v, input logic r, input logic rv, input logic [1:0] y,
                        input logic ecv, input logic [1:0] ecr, input int ew,
                        input logic [1:0] erv, input logic ey);
    vec_t t;
    t.cmd_v = v; t.cmd_rdy = r; t.resp_v = rv; t.yumi = y;
    t.exp_cmd_v = ecv; t.exp_cmd_rdy = ecr; t.exp_win = ew;
    t.exp_resp_v = erv; t.exp_yumi = ey;
    tbl.push_back(t);
  endtask

  function automatic int modelWinner(input logic [N-1:0] v);
    if (m_hold >= 0 && v[m_hold]) return m_hold;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Reference model advances on each rising edge from the rules, not the RTL
  always @(posedge clk_i) begin : model_update
    int w;
    bit issue;
    bit take;
    if (reset_i) begin
      mq.delete();
      m_ptr  = 0;
      m_hold = -1;
      m_err  = 1'b0;
    end else begin
      w     = modelWinner(mem_cmd_v_i);
      issue = (w >= 0) && (mq.size() < D);
      take  = (mq.size() > 0) && mem_resp_v_i && mem_resp_yumi_i[mq[0]];
      if (mem_resp_v_i && mq.size() == 0) m_err = 1'b1;
      if (take) void'(mq.pop_front());
      if (issue && mem_cmd_ready_i) begin
        mq.push_back(w);
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % N;
`endif
        m_hold = -1;
      end else if (issue) begin
        m_hold = w;
      end else begin
        m_hold = -1;
      end
    end
  end

  task automatic checkAgainstModel();
    int w;
    bit issue;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic exp_yumi;
    w        = modelWinner(mem_cmd_v_i);
    issue    = (w >= 0) && (mq.size() < D);
    exp_rdy  = '0;
    exp_rv   = '0;
    exp_yumi = 1'b0;
    if (issue && mem_cmd_ready_i) exp_rdy[w] = 1'b1;
    if (mq.size() > 0 && mem_resp_v_i) begin
      exp_rv[mq[0]] = 1'b1;
      exp_yumi      = mem_resp_yumi_i[mq[0]];
    end
    checkOutput("rand_cmd_v", 128'(mem_cmd_v_o), 128'(issue));
    checkOutput("rand_cmd_ready", 128'(mem_cmd_ready_o), 128'(exp_rdy));
    if (issue) checkOutput("rand_cmd_data", mem_cmd_o, req_data[w]);
    checkOutput("rand_resp_v", 128'(mem_resp_v_o), 128'(exp_rv));
    checkOutput("rand_resp_yumi", 128'(mem_resp_yumi_o), 128'(exp_yumi));
    checkOutput("rand_resp_data", mem_resp_o, mem_resp_i);
    checkOutput("rand_error", 128'(error_o), 128'(m_err));
  endtask

  initial begin
    req_data[0] = 128'hA0A0_0000_1111_2222_3333_4444_5555_0000;
    req_data[1] = 128'hB1B1_1111_6666_7777_8888_9999_AAAA_1111;
    mem_resp_i  = 128'hC0DE_0000_0000_0000_0000_0000_0000_0001;
    reset_i     = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b00);

    // Directed vectors, expected values derived by hand from a fresh reset
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00, 0);
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00, 0);
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00, 0);
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00, 0);
`else
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00, 0);
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b10, 1, 2'b00, 0);
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00, 0);
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b10, 1, 2'b00, 0);
`endif
    addRow(2'b11, 1, 0, 2'b00, 0, 2'b00, -1, 2'b00, 0);
    addRow(2'b11, 1, 1, 2'b11, 0, 2'b00, -1, 2'b01, 1);
    addRow(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00, 0);
    addRow(2'b11, 1, 0, 2'b00, 0, 2'b00, -1, 2'b00, 0);
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
    addRow(2'b00, 0, 1, 2'b11, 0, 2'b00, -1, 2'b01, 1);
    addRow(2'b00, 0, 1, 2'b11, 0, 2'b00, -1, 2'b01, 1);
    addRow(2'b00, 0, 1, 2'b01, 0, 2'b00, -1, 2'b01, 1);
    addRow(2'b00, 0, 1, 2'b10, 0, 2'b00, -1, 2'b01, 0);
`else
    addRow(2'b00, 0, 1, 2'b11, 0, 2'b00, -1, 2'b10, 1);
    addRow(2'b00, 0, 1, 2'b11, 0, 2'b00, -1, 2'b01, 1);
    addRow(2'b00, 0, 1, 2'b01, 0, 2'b00, -1, 2'b10, 0);
    addRow(2'b00, 0, 1, 2'b10, 0, 2'b00, -1, 2'b10, 1);
`endif
    addRow(2'b00, 0, 1, 2'b11, 0, 2'b00, -1, 2'b01, 1);
    addRow(2'b00, 0, 0, 2'b00, 0, 2'b00, -1, 2'b00, 0);

    // Reset state: outputs quiet during reset and in the first idle cycle
    nextCycle();
    @(negedge clk_i);
    checkOutput("reset_cmd_v", 128'(mem_cmd_v_o), 128'(0));
    checkOutput("reset_cmd_ready", 128'(mem_cmd_ready_o), 128'(0));
    checkOutput("reset_resp_v", 128'(mem_resp_v_o), 128'(0));
    checkOutput("reset_resp_yumi", 128'(mem_resp_yumi_o), 128'(0));
    nextCycle();
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_cmd_v", 128'(mem_cmd_v_o), 128'(0));
    checkOutput("post_reset_resp_v", 128'(mem_resp_v_o), 128'(0));
    checkOutput("post_reset_error", 128'(error_o), 128'(0));
    nextCycle();

    // Table-driven vectors
    for (int r = 0; r < tbl.size(); r++) begin
      applyStimulus(tbl[r].cmd_v, tbl[r].cmd_rdy, tbl[r].resp_v, tbl[r].yumi);
      @(negedge clk_i);
      checkOutput($sformatf("row%0d_cmd_v", r), 128'(mem_cmd_v_o), 128'(tbl[r].exp_cmd_v));
      checkOutput($sformatf("row%0d_cmd_ready", r), 128'(mem_cmd_ready_o), 128'(tbl[r].exp_cmd_rdy));
      if (tbl[r].exp_win >= 0)
        checkOutput($sformatf("row%0d_cmd_data", r), mem_cmd_o, req_data[tbl[r].exp_win]);
      checkOutput($sformatf("row%0d_resp_v", r), 128'(mem_resp_v_o), 128'(tbl[r].exp_resp_v));
      checkOutput($sformatf("row%0d_resp_yumi", r), 128'(mem_resp_yumi_o), 128'(tbl[r].exp_yumi));
      checkOutput($sformatf("row%0d_error", r), 128'(error_o), 128'(0));
      nextCycle();
    end

    // Stall hold: req1 stalled keeps the grant even when req0 shows up
    reset_i = 1'b1;
    applyStimulus(2'b00, 0, 0, 2'b00);
    nextCycle();
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus((c == 0) ? 2'b10 : 2'b11, 0, 0, 2'b00);
      @(negedge clk_i);
      checkOutput("stall_cmd_v", 128'(mem_cmd_v_o), 128'(1));
      checkOutput("stall_cmd_ready", 128'(mem_cmd_ready_o), 128'(0));
      checkOutput("stall_cmd_data", mem_cmd_o, req_data[1]);
      nextCycle();
    end
    applyStimulus(2'b11, 1, 0, 2'b00);
    @(negedge clk_i);
    checkOutput("stall_release_ready", 128'(mem_cmd_ready_o), 128'(2'b10));
    checkOutput("stall_release_data", mem_cmd_o, req_data[1]);
    nextCycle();
    @(negedge clk_i);
    checkOutput("after_stall_ready", 128'(mem_cmd_ready_o), 128'(2'b01));
    checkOutput("after_stall_data", mem_cmd_o, req_data[0]);
    nextCycle();

    // Reset with two commands outstanding, then a stray response
    reset_i = 1'b1;
    applyStimulus(2'b00, 0, 0, 2'b00);
    nextCycle();
    reset_i = 1'b0;
    applyStimulus(2'b00, 0, 1, 2'b11);
    @(negedge clk_i);
    checkOutput("stray_resp_v", 128'(mem_resp_v_o), 128'(0));
    checkOutput("stray_resp_yumi", 128'(mem_resp_yumi_o), 128'(0));
    checkOutput("stray_error_same_cycle", 128'(error_o), 128'(0));
    nextCycle();
    applyStimulus(2'b00, 0, 0, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checkOutput("stray_error_sticky", 128'(error_o), 128'(1));
      nextCycle();
    end
    reset_i = 1'b1;
    nextCycle();
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("error_cleared", 128'(error_o), 128'(0));
    nextCycle();

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) req_data[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_resp_i = {$urandom, $urandom, $urandom, $urandom};
      reset_i    = ($urandom_range(0, 299) == 0);
      applyStimulus(2'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) < 4), 2'($urandom));
      @(negedge clk_i);
      checkAgainstModel();
      nextCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
